// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, owner codes and tie-break helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle  = 2'd0,
    ArbIssue = 2'd1,
    ArbWait  = 2'd2,
    ArbDone  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OwnF = 1'b0,
    OwnD = 1'b1
  } owner_e;

  // On a tie the port that did not own the previous transaction wins.
  function automatic owner_e pick_owner(logic f_req, logic d_req, owner_e last_owner);
    if (f_req && d_req) begin
      return (last_owner == OwnD) ? OwnF : OwnD;
    end
    return f_req ? OwnF : OwnD;
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// 4-bit down counter timing the fixed memory read latency.
module mem_lat_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       is_one
);

  logic [3:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign is_one = (cnt_q == 4'd1);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch (F) and load/store (D) ports onto the single-ported unified memory,
// one transaction at a time, with fixed read latency and a one-cycle ack per transaction.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] LatLoad = 4'(MEM_LAT);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, last_owner_q, grant_owner;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q, f_rdata_q, d_rdata_q;
  logic              grant, cnt_load, cnt_dec, cnt_is_one, rd_capture;

  mem_lat_counter u_lat_counter (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (LatLoad),
    .dec      (cnt_dec),
    .is_one   (cnt_is_one)
  );

  assign grant_owner = pick_owner(f_req, d_req, last_owner_q);

  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      ArbIdle: begin
        if (f_req || d_req) begin
          grant   = 1'b1;
          state_d = ArbIssue;
        end
      end
      ArbIssue: begin
        cnt_load = 1'b1;
        state_d  = ArbWait;
      end
      ArbWait: begin
        cnt_dec = 1'b1;
        if (cnt_is_one) state_d = ArbDone;
      end
      ArbDone: state_d = ArbIdle;
      default: state_d = ArbIdle;
    endcase
  end

  assign rd_capture = (state_q == ArbWait) && cnt_is_one && !we_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ArbIdle;
      owner_q      <= OwnF;
      last_owner_q <= OwnD;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      f_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q <= grant_owner;
        addr_q  <= (grant_owner == OwnD) ? d_addr : f_addr;
        we_q    <= (grant_owner == OwnD) && d_we;
        // Fetches carry no write data, so keep the last store data on the bus.
        if (grant_owner == OwnD) wdata_q <= d_wdata;
      end
      if (rd_capture) begin
        if (owner_q == OwnD) d_rdata_q <= mem_rdata;
        else                 f_rdata_q <= mem_rdata;
      end
      if (state_q == ArbDone) last_owner_q <= owner_q;
    end
  end

  assign busy      = (state_q != ArbIdle);
  assign mem_en    = (state_q == ArbIssue);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign f_ack     = (state_q == ArbDone) && (owner_q == OwnF);
  assign d_ack     = (state_q == ArbDone) && (owner_q == OwnD);
  assign f_rdata   = f_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: 2-cycle RAM model plus a transaction-level reference.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned MEM_LAT = 2;
  localparam int          AckCyc  = MEM_LAT + 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              f_req, d_req, d_we;
  logic [ADDR_W-1:0] f_addr, d_addr, mem_addr;
  logic [DATA_W-1:0] d_wdata, f_rdata, d_rdata, mem_wdata, mem_rdata;
  logic              f_ack, d_ack, busy, mem_en, mem_we;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MEM_LAT (MEM_LAT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_ack     (f_ack),
    .f_rdata   (f_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .busy      (busy),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] init_val(input logic [31:0] a);
    return {a ^ 32'h5A5A_0000, ~a};
  endfunction

  // RAM: read data appears MEM_LAT cycles after mem_en and is garbage in every other cycle.
  logic [63:0] ram [logic [31:0]];
  logic [63:0] rd_p1;
  always @(posedge clock) begin
    if (mem_en && mem_we) ram[mem_addr] = mem_wdata;
    rd_p1     <= (mem_en && !mem_we) ? (ram.exists(mem_addr) ? ram[mem_addr] : init_val(mem_addr))
                                     : {$urandom, $urandom};
    mem_rdata <= rd_p1;
  end

  // Reference model state: architectural memory contents and per-port visible results.
  logic [63:0] shadow [logic [31:0]];
  bit          last_owner_m;  // 1 = D
  logic [63:0] exp_f_rdata, exp_d_rdata;

  function automatic logic [63:0] model_read(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    f_req = 1'b0;
    d_req = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset        = 1'b0;
    last_owner_m = 1'b1;
    exp_f_rdata  = '0;
    exp_d_rdata  = '0;
  endtask

  // Called #1 after a posedge, in an IDLE cycle, with requests already driven. Runs exactly one
  // transaction and returns #1 after the edge that ends its ack cycle.
  task automatic serve(input bit keep_req);
    bit          own_d, we;
    logic [31:0] a;
    logic [63:0] wd, exp_rd;
    own_d  = (f_req && d_req) ? (last_owner_m == 1'b0) : d_req;
    a      = own_d ? d_addr : f_addr;
    we     = own_d && d_we;
    wd     = d_wdata;
    exp_rd = we ? 64'd0 : model_read(a);
    for (int cyc = 0; cyc <= AckCyc; cyc++) begin
      @(negedge clock);
      chk("busy", busy, cyc != 0);
      chk("mem_en", mem_en, cyc == 1);
      chk("mem_we", mem_we, (cyc == 1) && we);
      if (cyc >= 1) chk("mem_addr", mem_addr, a);
      if (cyc >= 1 && we) chk("mem_wdata", mem_wdata, wd);
      chk("f_ack", f_ack, (cyc == AckCyc) && !own_d);
      chk("d_ack", d_ack, (cyc == AckCyc) && own_d);
      if (cyc == AckCyc) begin
        if (we) shadow[a] = wd;
        else if (own_d) exp_d_rdata = exp_rd;
        else exp_f_rdata = exp_rd;
        last_owner_m = own_d;
      end
      chk("f_rdata", f_rdata, exp_f_rdata);
      chk("d_rdata", d_rdata, exp_d_rdata);
      @(posedge clock);
      #1;
      if (cyc == 1) begin
        // Owner's inputs change mid-flight; the latched access must be unaffected.
        if (own_d) begin
          d_addr  = d_addr ^ 32'h300;
          d_we    = ~d_we;
          d_wdata = ~d_wdata;
        end else begin
          f_addr = f_addr ^ 32'h300;
        end
      end
      if (cyc == AckCyc && !keep_req) begin
        if (own_d) d_req = 1'b0;
        else f_req = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b1; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    f_addr = '0; d_addr = '0; d_wdata = '0;
    do_reset();

    @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_f_ack", f_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_f_rdata", f_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    @(posedge clock);
    #1;

    // Single fetch.
    f_req = 1'b1; f_addr = 32'h40;
    serve(0);

    // Store then load back the same address.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 64'hDEAD_BEEF;
    serve(0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    serve(0);

    // Tie straight after reset: F, then D, then F again.
    do_reset();
    f_req = 1'b1; f_addr = 32'h48;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    serve(0);
    serve(0);
    f_req = 1'b1; f_addr = 32'h50;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h58;
    serve(0);
    serve(0);

    // Address changed during WAIT (serve flips 0x100 to 0x200 mid-flight).
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    serve(0);

    // Reset during WAIT discards the load.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h180;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    chk("rstwait_d_ack", d_ack, 0);
    @(posedge clock);
    #1;
    reset = 1'b0; d_req = 1'b0;
    last_owner_m = 1'b1; exp_f_rdata = '0; exp_d_rdata = '0;
    @(negedge clock);
    chk("rstwait_busy", busy, 0);
    chk("rstwait_d_ack2", d_ack, 0);
    chk("rstwait_mem_en", mem_en, 0);
    chk("rstwait_mem_addr", mem_addr, 0);
    chk("rstwait_d_rdata", d_rdata, 0);
    @(posedge clock);
    #1;
    f_req = 1'b1; f_addr = 32'h60;
    serve(0);

    // d_req held high: back-to-back transactions, one every MEM_LAT+3 cycles.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_wdata = 64'h0123_4567_89AB_CDEF;
    serve(1);
    serve(1);
    serve(1);
    serve(0);

    // Randomized mix of single requests and ties.
    for (int i = 0; i < 30; i++) begin
      int mode;
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1;
      mode    = $urandom_range(0, 2);
      f_addr  = 32'($urandom_range(0, 31)) << 3;
      d_addr  = 32'($urandom_range(0, 31)) << 3;
      d_we    = 1'($urandom_range(0, 1));
      d_wdata = {$urandom, $urandom};
      f_req   = (mode != 1);
      d_req   = (mode != 0);
      serve(0);
      if (mode == 2) serve(0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
